pool_flatten_engine: RTL and testbench
======================================

// Module: pool_flatten_engine
// PURPOSE
//  Parametrised layer-1/layer-2 engine for the CONV pipeline. After the conv stage has filled
//  the layer-0 banks, it reads NCH conv-output maps, does 2x2 stride-2 max-pooling and writes
//  pooled maps to the layer-1 banks. Optionally it also writes a channel-interleaved flattened
//  vector to the layer-2 bank. It uses the same crd/cwr/csel memory bus as the conv stage.
// PARAMETERS
//  DW      20  data width (Q-format fixed point, passed through unchanged)
//  IMG_W   64  input map width = height; power of 2, >=4
//  NCH     2   channel count; 1, 2 or 4
//  SIGNED  1   1: max compare is two's-complement; 0: unsigned
//  AW      12  address width = 2*log2(IMG_W)
//  CSW     3   csel width, >= clog2(2*NCH+2)
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    synchronous, active-high
//  start     in   1    1-cycle pulse; sampled only in IDLE
//  flat_en   in   1    1: also produce layer-2 flatten; latched at start
//  busy      out  1    high from cycle after accepted start until DONE
//  done      out  1    1-cycle pulse after the last write
//  crd       out  1    read strobe
//  caddr_rd  out  AW   read address
//  cdata_rd  in   DW   read data; valid on the rising edge one cycle after crd/caddr_rd
//  cwr       out  1    write strobe; memory captures on this rising edge
//  caddr_wr  out  AW   write address
//  cdata_wr  out  DW   write data
//  csel      out  CSW  bank select: L0 ch c = 1+c, L1 ch c = 1+NCH+c, L2 = 1+2*NCH, idle = 0
// BEHAVIOUR
//  - Reset: all outputs 0; FSM goes to IDLE; counters cleared. Reset mid-operation aborts at
//    once; no further cwr. Memory contents already written are left as they are.
//  - Geometry: PW = IMG_W/2. Output index k = r*PW + q, with r,q in [0,PW).
//    Inputs for k are read in this order: (2r,2q), (2r,2q+1), (2r+1,2q), (2r+1,2q+1).
//    L0 address = row*IMG_W + col.
//  - Loop order: channel c outer (0..NCH-1), then k ascending (0..PW*PW-1).
//  - FSM: IDLE -> RD0..RD3 -> CAP -> WL1 -> [WL2 if flat_en] -> next k or next c -> ... -> DONE -> IDLE.
//    RDn: crd=1, csel=L0(c), caddr_rd=nth input.
//    RD1..RD3 and CAP: capture cdata_rd from the previous cycle into a running max. The first
//    sample loads the max unconditionally. On a tie the current max is kept.
//    WL1: cwr=1, csel=L1(c), caddr_wr=k, cdata_wr=max.
//    WL2: cwr=1, csel=L2, caddr_wr=k*NCH+c, cdata_wr=max.
//    DONE: done=1, busy=0 (busy stays high through the last write cycle).
//  - Per output: 6 cycles if flat_en=0, 7 if flat_en=1.
//    Total from start to done = NCH*PW*PW*(6|7) + 2 cycles.
//  - crd and cwr are never both high. csel=0 and strobes=0 in any cycle without an access.
//    Addresses and data hold their last value when the strobe is low.
//  - start while busy is ignored. start in the DONE cycle is ignored.
//  - Arithmetic: no rounding or saturation; output = one of the 4 input words, bit-exact.
//  - Boundaries: the last k of the last channel goes straight to DONE. k wraps to 0 and c
//    increments with no idle gap.
// TESTING (default parameters unless stated)
//  1 reset=1 for 3 cycles, then idle -> all outputs 0, busy=0, no strobe for 100 cycles.
//  2 L0 ch0 addr n = n, ch1 = 4095-n, flat_en=0 -> L1_0[k] = (2r+1)*64+2q+1;
//    L1_1[k] = 4095-(2r*64+2q); L2 untouched; done at cycle 2*1024*6+2 = 12290.
//  3 Same data, flat_en=1 -> L2[2k] = L1_0[k], L2[2k+1] = L1_1[k]; done at cycle 14338.
//  4 SIGNED=1, window {20'hFFFFF, 20'h80000, 20'h00000, 20'hFFFFE} -> 20'h00000;
//    SIGNED=0 gives 20'hFFFFF.
//  5 reset asserted at cycle 5000 of test 2 -> cwr=0 from the next edge, busy=0;
//    a new start then reproduces test 2 exactly.
//  6 IMG_W=8, NCH=4, flat_en=1, start pulsed again while busy -> ignored;
//    L2 addr = k*4+c for 64 entries; done at 4*16*7+2 = 450.

Source files
------------

// File: rtl/pool_flatten_engine.sv
// 2x2 stride-2 max-pool over NCH conv maps, writing pooled maps to the layer-1 banks and,
// optionally, a channel-interleaved flattened vector to the layer-2 bank.
module pool_flatten_engine #(
  parameter int DW     = 20,
  parameter int IMG_W  = 64,
  parameter int NCH    = 2,
  parameter int SIGNED = 1,
  parameter int AW     = 12,
  parameter int CSW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           flat_en,
  output logic           busy,
  output logic           done,
  output logic           crd,
  output logic [AW-1:0]  caddr_rd,
  input  logic [DW-1:0]  cdata_rd,
  output logic           cwr,
  output logic [AW-1:0]  caddr_wr,
  output logic [DW-1:0]  cdata_wr,
  output logic [CSW-1:0] csel
);
  // state | meaning
  // IDLE  | waiting for start
  // RD0-3 | read the four window inputs of output k
  // CAP   | capture the fourth input into the running max
  // WL1   | write max to layer-1 bank of channel c
  // WL2   | write max to layer-2 bank at k*NCH+c (flatten only)
  // DONE  | one-cycle done pulse
  localparam int LW  = $clog2(IMG_W);
  localparam int PLW = LW - 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_WL1, S_WL2, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PLW-1:0] r_q, q_q;
  logic [CW-1:0]  c_q;
  logic           flat_q;
  logic [DW-1:0]  max_q;
  logic [AW-1:0]  rd_addr_hold, wr_addr_hold;
  logic [DW-1:0]  wr_data_hold;

  logic           last_k, last_c, wr_last, gt, dy, dx;
  logic [AW-1:0]  rd_addr_now, l1_addr, l2_addr;

  assign last_k  = &{r_q, q_q};
  assign last_c  = (c_q == CW'(NCH - 1));
  assign wr_last = ((state == S_WL1) && !flat_q) || (state == S_WL2);

  // Window position: RD1/RD3 take the odd column, RD2/RD3 the odd row.
  assign dy          = (state == S_RD2) || (state == S_RD3);
  assign dx          = (state == S_RD1) || (state == S_RD3);
  assign rd_addr_now = AW'({r_q, dy, q_q, dx});
  assign l1_addr     = AW'({r_q, q_q});
  assign l2_addr     = l1_addr * AW'(NCH) + AW'(c_q);

  always_comb begin
    gt = 1'b0;
    if (SIGNED != 0) gt = $signed(cdata_rd) > $signed(max_q);
    else             gt = cdata_rd > max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RD0;
      S_RD0:   state_nxt = S_RD1;
      S_RD1:   state_nxt = S_RD2;
      S_RD2:   state_nxt = S_RD3;
      S_RD3:   state_nxt = S_CAP;
      S_CAP:   state_nxt = S_WL1;
      S_WL1:   if (flat_q)               state_nxt = S_WL2;
               else if (last_k && last_c) state_nxt = S_DONE;
               else                      state_nxt = S_RD0;
      S_WL2:   state_nxt = (last_k && last_c) ? S_DONE : S_RD0;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= '0;
      q_q          <= '0;
      c_q          <= '0;
      flat_q       <= 1'b0;
      max_q        <= '0;
      rd_addr_hold <= '0;
      wr_addr_hold <= '0;
      wr_data_hold <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        flat_q <= flat_en;
        r_q    <= '0;
        q_q    <= '0;
        c_q    <= '0;
      end
      // Read data lags the strobe by one cycle, so RD1 sees the RD0 word.
      if ((state == S_RD1) || (((state == S_RD2) || (state == S_RD3) || (state == S_CAP)) && gt))
        max_q <= cdata_rd;
      if (wr_last) begin
        if (last_k) begin
          r_q <= '0;
          q_q <= '0;
          if (!last_c) c_q <= c_q + 1'b1;
        end else begin
          {r_q, q_q} <= {r_q, q_q} + 1'b1;
        end
      end
      if (crd) rd_addr_hold <= caddr_rd;
      if (cwr) begin
        wr_addr_hold <= caddr_wr;
        wr_data_hold <= cdata_wr;
      end
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = '0;
    caddr_rd = rd_addr_hold;
    caddr_wr = wr_addr_hold;
    cdata_wr = wr_data_hold;
    unique case (state)
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = CSW'(1) + CSW'(c_q);
        caddr_rd = rd_addr_now;
      end
      S_CAP: busy = 1'b1;
      S_WL1: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSW'(1 + NCH) + CSW'(c_q);
        caddr_wr = l1_addr;
        cdata_wr = max_q;
      end
      S_WL2: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSW'(1 + 2 * NCH);
        caddr_wr = l2_addr;
        cdata_wr = max_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pool_flatten_engine.sv
// Bench for pool_flatten_engine: a 64x64x2 signed instance checked cycle by cycle against
// a timing/arithmetic model, and an 8x8x4 unsigned instance for flatten layout and start filtering.
module tb_pool_flatten_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, flat_en_a, start_b, flat_en_b;

  logic        busy_a, done_a, crd_a, cwr_a;
  logic [11:0] caddr_rd_a, caddr_wr_a;
  logic [19:0] cdata_rd_a, cdata_wr_a;
  logic [2:0]  csel_a;

  logic        busy_b, done_b, crd_b, cwr_b;
  logic [5:0]  caddr_rd_b, caddr_wr_b;
  logic [19:0] cdata_rd_b, cdata_wr_b;
  logic [3:0]  csel_b;

  pool_flatten_engine #(.DW(20), .IMG_W(64), .NCH(2), .SIGNED(1), .AW(12), .CSW(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .flat_en(flat_en_a), .busy(busy_a),
    .done(done_a), .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a), .cwr(cwr_a),
    .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a), .csel(csel_a));

  pool_flatten_engine #(.DW(20), .IMG_W(8), .NCH(4), .SIGNED(0), .AW(6), .CSW(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .flat_en(flat_en_b), .busy(busy_b),
    .done(done_b), .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b), .cwr(cwr_b),
    .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b), .csel(csel_b));

  logic [19:0] l0a [2][4096];
  logic [19:0] l1a [2][1024];
  logic [19:0] l2a [2048];
  int          l1_cnt_a = 0, l2_cnt_a = 0;

  logic [19:0] l0b [4][64];
  logic [19:0] l1b [4][16];
  logic [19:0] l2b [64];
  int          l1_cnt_b = 0, l2_cnt_b = 0;

  always @(posedge clk) begin
    if (crd_a && csel_a >= 1 && csel_a <= 2) cdata_rd_a <= l0a[int'(csel_a) - 1][caddr_rd_a];
    if (cwr_a) begin
      if (csel_a >= 3 && csel_a <= 4) begin
        l1a[int'(csel_a) - 3][caddr_wr_a[9:0]] <= cdata_wr_a;
        l1_cnt_a <= l1_cnt_a + 1;
      end else if (csel_a == 5) begin
        l2a[caddr_wr_a[10:0]] <= cdata_wr_a;
        l2_cnt_a <= l2_cnt_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (crd_b && csel_b >= 1 && csel_b <= 4) cdata_rd_b <= l0b[int'(csel_b) - 1][caddr_rd_b];
    if (cwr_b) begin
      if (csel_b >= 5 && csel_b <= 8) begin
        l1b[int'(csel_b) - 5][caddr_wr_b[3:0]] <= cdata_wr_b;
        l1_cnt_b <= l1_cnt_b + 1;
      end else if (csel_b == 9) begin
        l2b[caddr_wr_b] <= cdata_wr_b;
        l2_cnt_b <= l2_cnt_b + 1;
      end
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Max of the 2x2 window as two's-complement numbers.
  function automatic logic [19:0] ref_a(int c, int k);
    int r = k / 32, q = k % 32;
    logic signed [19:0] m, v;
    m = l0a[c][(2 * r) * 64 + 2 * q];
    for (int n = 1; n < 4; n++) begin
      v = l0a[c][(2 * r + n / 2) * 64 + 2 * q + n % 2];
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Max of the 2x2 window as unsigned numbers.
  function automatic logic [19:0] ref_b(int c, int k);
    int r = k / 4, q = k % 4;
    logic [19:0] m, v;
    m = l0b[c][(2 * r) * 8 + 2 * q];
    for (int n = 1; n < 4; n++) begin
      v = l0b[c][(2 * r + n / 2) * 8 + 2 * q + n % 2];
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Cycle 1 is the start cycle; output o occupies cycles 2+o*per .. 1+(o+1)*per.
  task automatic run_a(input bit flat, input int abort_at);
    int per, total, s, o, p, c, k, r, q, cnt0;
    bit e_rd, e_wr;
    per   = flat ? 7 : 6;
    total = 2 * 1024 * per + 2;
    @(negedge clk);
    start_a = 1'b1; flat_en_a = flat;
    chk("busy_before_start", busy_a, 0);
    for (int cyc = 2; cyc <= total + 3; cyc++) begin
      @(negedge clk);
      start_a   = 1'b0;
      flat_en_a = !flat;
      s = cyc - 2; o = s / per; p = s % per; c = o / 1024; k = o % 1024;
      r = k / 32; q = k % 32;
      e_rd = (cyc < total) && (p < 4);
      e_wr = (cyc < total) && (p >= 5);
      chk("crd", crd_a, e_rd);
      chk("cwr", cwr_a, e_wr);
      chk("busy", busy_a, cyc < total);
      chk("done", done_a, cyc == total);
      if (e_rd) begin
        chk("rd_csel", csel_a, 1 + c);
        chk("rd_addr", caddr_rd_a, (2 * r + p / 2) * 64 + 2 * q + p % 2);
      end else if (e_wr && p == 5) begin
        chk("l1_csel", csel_a, 3 + c);
        chk("l1_addr", caddr_wr_a, k);
        chk("l1_data", cdata_wr_a, ref_a(c, k));
      end else if (e_wr) begin
        chk("l2_csel", csel_a, 5);
        chk("l2_addr", caddr_wr_a, k * 2 + c);
        chk("l2_data", cdata_wr_a, ref_a(c, k));
      end else begin
        chk("idle_csel", csel_a, 0);
      end
      if (abort_at > 0 && cyc == abort_at) begin
        reset = 1'b1;
        cnt0  = l1_cnt_a;
        @(negedge clk);
        chk("abort_cwr", cwr_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_crd_csel", {crd_a, csel_a}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_writes", l1_cnt_a, cnt0);
        chk("abort_stays_idle", busy_a, 0);
        return;
      end
    end
  endtask

  task automatic run_b();
    int total, s, o, p, c, k;
    total = 4 * 16 * 7 + 2;
    @(negedge clk);
    start_b = 1'b1; flat_en_b = 1'b1;
    for (int cyc = 2; cyc <= total + 10; cyc++) begin
      @(negedge clk);
      flat_en_b = 1'b0;
      start_b   = (cyc == 10) || (cyc == total);
      s = cyc - 2; o = s / 7; p = s % 7; c = o / 16; k = o % 16;
      chk("b_busy", busy_b, cyc < total);
      chk("b_done", done_b, cyc == total);
      if (cyc < total && p == 6) begin
        chk("b_l2_strobe", {cwr_b, csel_b}, {1'b1, 4'd9});
        chk("b_l2_addr", caddr_wr_b, k * 4 + c);
        chk("b_l2_data", cdata_wr_b, ref_b(c, k));
      end
    end
    start_b = 1'b0;
  endtask

  task automatic check_pattern_l1();
    int r, q;
    for (int k = 0; k < 1024; k++) begin
      r = k / 32; q = k % 32;
      chk("pat_l1_0", l1a[0][k], (2 * r + 1) * 64 + 2 * q + 1);
      chk("pat_l1_1", l1a[1][k], 4095 - (2 * r * 64 + 2 * q));
    end
  endtask

  int l2c0;

  initial begin
    reset = 1'b1; start_a = 1'b0; flat_en_a = 1'b0; start_b = 1'b0; flat_en_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_a", {crd_a, cwr_a, csel_a, caddr_rd_a, caddr_wr_a, cdata_wr_a, busy_a, done_a}, 0);
      chk("idle_b", {crd_b, cwr_b, csel_b, caddr_rd_b, caddr_wr_b, cdata_wr_b, busy_b, done_b}, 0);
    end

    for (int n = 0; n < 4096; n++) begin
      l0a[0][n] = 20'(n);
      l0a[1][n] = 20'(4095 - n);
    end
    l2c0 = l2_cnt_a;
    run_a(1'b0, 0);
    check_pattern_l1();
    chk("pin_l1_0_k0", l1a[0][0], 65);
    chk("pin_l1_0_last", l1a[0][1023], 4095);
    chk("pin_l1_1_k0", l1a[1][0], 4095);
    chk("pin_l1_1_last", l1a[1][1023], 65);
    chk("l2_untouched", l2_cnt_a, l2c0);

    run_a(1'b0, 5000);
    run_a(1'b0, 0);
    check_pattern_l1();

    for (int c = 0; c < 2; c++)
      for (int n = 0; n < 4096; n++) l0a[c][n] = 20'($urandom);
    l0a[0][0] = 20'hFFFFF; l0a[0][1] = 20'h80000; l0a[0][64] = 20'h00000; l0a[0][65] = 20'hFFFFE;
    chk("pin_signed_model", ref_a(0, 0), 20'h00000);
    run_a(1'b1, 0);
    chk("signed_window_l1", l1a[0][0], 20'h00000);
    chk("signed_window_l2", l2a[0], 20'h00000);
    for (int k = 0; k < 1024; k++)
      for (int c = 0; c < 2; c++) begin
        chk("rand_l1", l1a[c][k], ref_a(c, k));
        chk("rand_l2", l2a[k * 2 + c], ref_a(c, k));
      end

    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 64; n++) l0b[c][n] = 20'($urandom);
    l0b[0][0] = 20'hFFFFF; l0b[0][1] = 20'h80000; l0b[0][8] = 20'h00000; l0b[0][9] = 20'hFFFFE;
    chk("pin_unsigned_model", ref_b(0, 0), 20'hFFFFF);
    run_b();
    chk("unsigned_window_l1", l1b[0][0], 20'hFFFFF);
    chk("b_l1_writes", l1_cnt_b, 64);
    chk("b_l2_writes", l2_cnt_b, 64);
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < 4; c++) begin
        chk("b_l1", l1b[c][k], ref_b(c, k));
        chk("b_l2", l2b[k * 4 + c], ref_b(c, k));
      end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
